irig_frame_decoder: RTL
=======================

// Module: irig_frame_decoder
// PURPOSE
//  Consumes the per-pulse symbol stream (0=bit 0, 1=bit 1, 2=position marker) from the IRIG pulse-width
//  classifier. Aligns to the 100-symbol IRIG-B frame (double marker = P0 then Pr) and checks all P1..P9.
//  Decodes the BCD time-of-year fields to binary and presents one timestamp per frame to the timing logic.
// PARAMETERS
//  TIMEOUT   100_000_000  max clk cycles between symbol_valid strobes before lock is dropped (~1 s @100 MHz)
// PORTS
//  clk           in   1   system clock, all logic on rising edge
//  rst           in   1   synchronous active-high reset
//  symbol        in   2   classified pulse: 0, 1, 2=marker, 3=illegal
//  symbol_valid  in   1   one-cycle strobe qualifying symbol
//  seconds       out  6   0..59
//  minutes       out  6   0..59
//  hours         out  5   0..23
//  days          out  9   1..366
//  years         out  7   0..99
//  frame_valid   out  1   one-cycle pulse, time outputs updated same cycle
//  locked        out  1   high while in RUN
//  sync_err      out  1   one-cycle pulse on framing loss (bad marker, illegal symbol, timeout)
//  bcd_err       out  1   one-cycle pulse when a framed frame holds out-of-range BCD
//  sbs           out  17  straight binary seconds of day (only with IRIG_SBS_EN, else port absent)
// BEHAVIOUR
//  Reset: all outputs 0, FSM=HUNT, index=0, shift register and timeout counter cleared. Mid-frame reset aborts.
//  FSM (advances only on symbol_valid, except timeout):
//   HUNT: symbol==2 -> SYNC; else stay.
//   SYNC: symbol==2 -> RUN, index=1 (this is Pr); symbol 0/1 -> HUNT; 3 -> HUNT.
//   RUN:  symbol stored at position index; index 9,19,..,99 must be 2, all others must be 0/1.
//         Violation or symbol==3 -> HUNT + sync_err. index 99 accepted -> decode, then expect Pr:
//         next symbol==2 -> index=1, stay RUN; else -> HUNT + sync_err.
//  Timeout: counter clears on every symbol_valid; in SYNC/RUN reaching TIMEOUT -> HUNT (+sync_err if RUN).
//  Simultaneous symbol_valid and timeout terminal count: symbol wins, counter clears.
//  Fields, LSB-first within frame: sec units 1-4, tens 6-8; min units 10-13, tens 15-17;
//   hour units 20-23, tens 25-26; day units 30-33, tens 35-38, hundreds 40-41; year units 50-53, tens 55-58.
//  Binary = units + 10*tens (+100*hundreds), computed with shift-adds, widths as ports, no truncation.
//  Range check: any digit >9, sec/min>59, hour>23, day 0 or >366 -> bcd_err, outputs held, no frame_valid.
//  Latency: frame_valid and updated fields 2 cycles after the symbol_valid of P0 (index 99).
//  Decoded time is the Pr instant of the frame just completed (~1 s old); consumer adds 1 s.
//  Outputs hold last good frame through loss of lock; locked deasserts same cycle as sync_err.
// CONFIGURATION
//  IRIG_SBS_EN defined: decode SBS bits 80-88 (b0..b8) and 90-97 (b9..b16) into sbs, updated with
//   frame_valid; sbs>86399 raises bcd_err. Undefined: bits 80-97 ignored, sbs port and logic removed.
// STRUCTURE
//  irig_defs.vh (shared): symbol codes SYM_ZERO/SYM_ONE/SYM_MARK/SYM_ILL, FSM state encodings,
//   frame length 100, field bit-position constants.
//  Sub-module irig_bcd2bin: up to 3 BCD digits -> binary plus digit-range flag; one instance per field.
//  Top holds FSM, index counter, 100-bit shift register, timeout counter, output registers.
// TESTING
//  Clean frame 123 d 14:37:52 y24 after double marker -> frame_valid 2 cycles after P0, fields match, locked=1.
//  Marker replaced by 1 at index 49 -> sync_err pulse, locked=0, outputs keep previous frame, re-lock next P0/Pr.
//  Seconds tens=6 (sec=65) in framed stream -> bcd_err, no frame_valid, stays locked, next good frame decodes.
//  Stop symbols for TIMEOUT cycles (TIMEOUT=1000 in sim) while RUN -> sync_err, HUNT; resume -> relocks.
//  Assert rst at index 40 -> all outputs 0 next cycle; full frame afterwards decodes correctly.
//  IRIG_SBS_EN: 14:37:52 frame with SBS=52672 -> sbs=52672 with frame_valid; undefined -> bench compiles w/o sbs.

Source files
------------

// File: rtl/irig_frame_decoder_pkg.sv
// Shared symbol codes, FSM encodings and IRIG-B frame bit positions for irig_frame_decoder.
package irig_frame_decoder_pkg;

  localparam logic [1:0] SymZero = 2'd0;
  localparam logic [1:0] SymOne  = 2'd1;
  localparam logic [1:0] SymMark = 2'd2;
  localparam logic [1:0] SymIll  = 2'd3;

  localparam logic [1:0] StHunt = 2'd0;
  localparam logic [1:0] StSync = 2'd1;
  localparam logic [1:0] StRun  = 2'd2;

  localparam int unsigned FrameLen = 100;

  localparam int unsigned SecUnitsPos  = 1;
  localparam int unsigned SecTensPos   = 6;
  localparam int unsigned MinUnitsPos  = 10;
  localparam int unsigned MinTensPos   = 15;
  localparam int unsigned HourUnitsPos = 20;
  localparam int unsigned HourTensPos  = 25;
  localparam int unsigned DayUnitsPos  = 30;
  localparam int unsigned DayTensPos   = 35;
  localparam int unsigned DayHundPos   = 40;
  localparam int unsigned YearUnitsPos = 50;
  localparam int unsigned YearTensPos  = 55;
  localparam int unsigned SbsLoPos     = 80;
  localparam int unsigned SbsHiPos     = 90;

  typedef struct packed {
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic [4:0] hours;
    logic [8:0] days;
    logic [6:0] years;
  } irig_time_t;

  function automatic logic is_marker_pos(input logic [6:0] idx);
    case (idx)
      7'd9, 7'd19, 7'd29, 7'd39, 7'd49, 7'd59, 7'd69, 7'd79, 7'd89, 7'd99: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/irig_frame_decoder_bcd2bin.sv
// Up to three BCD digits to binary via shift-adds, with a flag for any digit above 9.
module irig_frame_decoder_bcd2bin (
  input  logic [3:0] units_i,
  input  logic [3:0] tens_i,
  input  logic [3:0] hundreds_i,
  output logic [9:0] bin_o,
  output logic       digit_err_o
);

  assign bin_o = 10'(units_i)
               + (10'(tens_i) << 3) + (10'(tens_i) << 1)
               + (10'(hundreds_i) << 6) + (10'(hundreds_i) << 5) + (10'(hundreds_i) << 2);

  assign digit_err_o = (units_i > 4'd9) || (tens_i > 4'd9) || (hundreds_i > 4'd9);

endmodule

// File: rtl/irig_frame_decoder.sv
// IRIG-B frame aligner and BCD time decoder. Define IRIG_SBS_EN to add the straight-binary-seconds
// field output (sbs).
module irig_frame_decoder
  import irig_frame_decoder_pkg::*;
#(
  parameter int unsigned TIMEOUT = 100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  symbol,
  input  logic        symbol_valid,
  output logic [5:0]  seconds,
  output logic [5:0]  minutes,
  output logic [4:0]  hours,
  output logic [8:0]  days,
  output logic [6:0]  years,
  output logic        frame_valid,
  output logic        locked,
  output logic        sync_err,
  output logic        bcd_err
`ifdef IRIG_SBS_EN
  ,
  output logic [16:0] sbs
`endif
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [1:0]          state_q, state_d;
  logic [6:0]          index_q, index_d;
  logic [FrameLen-1:0] sr_q, sr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                decode_q, decode_d;
  logic                sync_err_q, sync_err_d;
  logic                frame_valid_q, bcd_err_q;
  irig_time_t          time_q, time_d;
  logic                violation, range_err, sbs_err;

  // Markers are legal only on marker positions; position 0 (index_q == 0) is the Pr slot.
  assign violation = (symbol == SymIll) ||
                     (is_marker_pos(index_q) ? (symbol != SymMark) : (symbol == SymMark));

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    decode_d   = 1'b0;
    sync_err_d = 1'b0;
    if (symbol_valid) begin
      cnt_d = '0;
      case (state_q)
        StHunt: if (symbol == SymMark) state_d = StSync;
        StSync: begin
          if (symbol == SymMark) begin
            state_d = StRun;
            index_d = 7'd1;
          end else begin
            state_d = StHunt;
          end
        end
        StRun: begin
          if (index_q == 7'd0) begin
            if (symbol == SymMark) begin
              index_d = 7'd1;
            end else begin
              state_d    = StHunt;
              sync_err_d = 1'b1;
            end
          end else if (violation) begin
            state_d    = StHunt;
            sync_err_d = 1'b1;
          end else begin
            // After positions 1..99 have been shifted in, sr_q[p] holds frame bit p.
            sr_d = {(symbol != SymZero), sr_q[FrameLen-1:1]};
            if (index_q == 7'(FrameLen - 1)) begin
              index_d  = 7'd0;
              decode_d = 1'b1;
            end else begin
              index_d = index_q + 7'd1;
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end else if (state_q != StHunt) begin
      if (cnt_q == CntW'(TIMEOUT - 1)) begin
        state_d    = StHunt;
        cnt_d      = '0;
        sync_err_d = (state_q == StRun);
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  logic [9:0] sec_bin, min_bin, hour_bin, day_bin, year_bin;
  logic       sec_derr, min_derr, hour_derr, day_derr, year_derr;

  irig_frame_decoder_bcd2bin u_sec (
    .units_i     (sr_q[SecUnitsPos +: 4]),
    .tens_i      ({1'b0, sr_q[SecTensPos +: 3]}),
    .hundreds_i  (4'd0),
    .bin_o       (sec_bin),
    .digit_err_o (sec_derr)
  );

  irig_frame_decoder_bcd2bin u_min (
    .units_i     (sr_q[MinUnitsPos +: 4]),
    .tens_i      ({1'b0, sr_q[MinTensPos +: 3]}),
    .hundreds_i  (4'd0),
    .bin_o       (min_bin),
    .digit_err_o (min_derr)
  );

  irig_frame_decoder_bcd2bin u_hour (
    .units_i     (sr_q[HourUnitsPos +: 4]),
    .tens_i      ({2'b00, sr_q[HourTensPos +: 2]}),
    .hundreds_i  (4'd0),
    .bin_o       (hour_bin),
    .digit_err_o (hour_derr)
  );

  irig_frame_decoder_bcd2bin u_day (
    .units_i     (sr_q[DayUnitsPos +: 4]),
    .tens_i      (sr_q[DayTensPos +: 4]),
    .hundreds_i  ({2'b00, sr_q[DayHundPos +: 2]}),
    .bin_o       (day_bin),
    .digit_err_o (day_derr)
  );

  irig_frame_decoder_bcd2bin u_year (
    .units_i     (sr_q[YearUnitsPos +: 4]),
    .tens_i      (sr_q[YearTensPos +: 4]),
    .hundreds_i  (4'd0),
    .bin_o       (year_bin),
    .digit_err_o (year_derr)
  );

`ifdef IRIG_SBS_EN
  logic [16:0] sbs_bin, sbs_q;
  assign sbs_bin = {sr_q[SbsHiPos +: 8], sr_q[SbsLoPos +: 9]};
  assign sbs_err = (sbs_bin > 17'd86399);
  assign sbs     = sbs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sbs_q <= '0;
    end else if (decode_q && !range_err) begin
      sbs_q <= sbs_bin;
    end
  end
`else
  assign sbs_err = 1'b0;
`endif

  assign range_err = sec_derr | min_derr | hour_derr | day_derr | year_derr | sbs_err
                   | (sec_bin > 10'd59) | (min_bin > 10'd59) | (hour_bin > 10'd23)
                   | (day_bin == 10'd0) | (day_bin > 10'd366);

  always_comb begin
    time_d         = time_q;
    time_d.seconds = sec_bin[5:0];
    time_d.minutes = min_bin[5:0];
    time_d.hours   = hour_bin[4:0];
    time_d.days    = day_bin[8:0];
    time_d.years   = year_bin[6:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StHunt;
      index_q       <= '0;
      sr_q          <= '0;
      cnt_q         <= '0;
      decode_q      <= 1'b0;
      sync_err_q    <= 1'b0;
      frame_valid_q <= 1'b0;
      bcd_err_q     <= 1'b0;
      time_q        <= '0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      sr_q          <= sr_d;
      cnt_q         <= cnt_d;
      decode_q      <= decode_d;
      sync_err_q    <= sync_err_d;
      frame_valid_q <= decode_q & ~range_err;
      bcd_err_q     <= decode_q & range_err;
      if (decode_q && !range_err) time_q <= time_d;
    end
  end

  assign seconds     = time_q.seconds;
  assign minutes     = time_q.minutes;
  assign hours       = time_q.hours;
  assign days        = time_q.days;
  assign years       = time_q.years;
  assign frame_valid = frame_valid_q;
  assign bcd_err     = bcd_err_q;
  assign sync_err    = sync_err_q;
  assign locked      = (state_q == StRun);

  // Marker, spare and (without SBS) control-field bits are intentionally not decoded.
  logic unused_bits;
  assign unused_bits = ^{sr_q, sec_bin[9:6], min_bin[9:6], hour_bin[9:5], day_bin[9], year_bin[9:7]};

endmodule
